// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped console transmitter: register map,
// STATUS bit layout and the serial framing state encoding.
package mmio_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // The STATUS count field is only four bits wide, so deeper FIFOs clamp at 15.
  function automatic logic [3:0] sat_count(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with pointers one bit wider than the index so that full
// and empty are distinguishable; a push into a full FIFO is taken if a pop
// frees the head slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mmio_console_tx.sv
// Memory-mapped 8N1 console transmitter: bus decode, TXDATA/STATUS/DIVISOR
// registers, a byte FIFO and the serial framing state machine.
module mmio_console_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h800,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit, wr_en, rd_en;
  logic [1:0]    idx;
  logic          push_req, pop;
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status_w;
  logic [15:0]   eff_div;
  logic          unused_wdata;

  logic [31:0] rdata_q, rdata_d;
  logic        sel_q, sel_d;
  logic [15:0] div_q, div_d;
  logic        overflow_q, overflow_d;

  tx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [15:0] period_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic        tx_q;

  assign hit      = (address[31:4] == BASE_ADDR[31:4]) && (address[1:0] == 2'b00);
  assign idx      = address[3:2];
  assign wr_en    = hit && we;
  assign rd_en    = hit && !we;
  assign push_req = wr_en && (idx == REG_TXDATA);
  assign pop      = (state_q == TX_IDLE) && !fifo_empty;
  assign eff_div  = (div_q == 16'd0) ? 16'd1 : div_q;

  assign unused_wdata = ^wdata[31:16];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push_req),
    .push_data_i (wdata[7:0]),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    status_w                       = '0;
    status_w[STAT_FULL]            = fifo_full;
    status_w[STAT_EMPTY]           = fifo_empty;
    status_w[STAT_BUSY]            = (state_q != TX_IDLE);
    status_w[STAT_OVF]             = overflow_q;
    status_w[STAT_CNT_LSB +: 4]    = sat_count(32'(fifo_count));
  end

  // Reads sample the pre-edge state, so a read racing a push/pop sees the old view.
  always_comb begin
    rdata_d    = rdata_q;
    sel_d      = rd_en;
    div_d      = div_q;
    overflow_d = overflow_q;
    if (rd_en) begin
      case (idx)
        REG_TXDATA, REG_STATUS: rdata_d = status_w;
        REG_DIV:                rdata_d = {16'h0000, div_q};
        default:                rdata_d = '0;
      endcase
    end
    if (wr_en && (idx == REG_DIV)) div_d = wdata[15:0];
    if (wr_en && (idx == REG_STATUS) && wdata[STAT_OVF]) overflow_d = 1'b0;
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q    <= '0;
      sel_q      <= 1'b0;
      div_q      <= DIV_RESET;
      overflow_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
      overflow_q <= overflow_d;
    end
  end

  // Each framing state lasts one bit period, timed by cnt_q counting down to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= TX_IDLE;
      shift_q  <= '0;
      period_q <= 16'd1;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q  <= fifo_head;
            period_q <= eff_div;
            cnt_q    <= eff_div - 16'd1;
            tx_q     <= 1'b0;
            state_q  <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_q == 16'd0) begin
            cnt_q   <= period_q - 16'd1;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= 3'd0;
            state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (cnt_q == 16'd0) begin
            cnt_q <= period_q - 16'd1;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (cnt_q == 16'd0) begin
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign sel   = sel_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_mmio_console_tx.sv
// Self-checking bench for mmio_console_tx: directed scenarios plus random bus
// traffic, compared cycle by cycle against a frame-timeline reference model.
module tb_mmio_console_tx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] address, wdata;
  logic        we;
  logic [31:0] rdata;
  logic        sel, tx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mmio_console_tx #(
    .BASE_ADDR  (32'h800),
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (16'd4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .address (address),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .sel     (sel),
    .tx      (tx)
  );

  // Reference model: a byte queue plus the start edge, period and byte of the
  // frame on the line; the expected line level is derived from elapsed time.
  logic [7:0]  mq[$];
  logic        m_active;
  int          m_start, m_period, m_edge;
  logic [7:0]  m_byte;
  logic        m_ovf;
  logic [15:0] m_div;
  logic [31:0] exp_rdata;
  logic        exp_sel, exp_tx;
  logic        m_hit, m_do_pop;
  logic [31:0] m_rd_val;
  int          m_t, m_b;

  function automatic logic hit_of(input logic [31:0] a);
    return (a[31:4] == 28'h0000080) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n    = mq.size();
    s    = '0;
    s[7:4] = (n > 15) ? 4'hF : 4'(n);
    s[3] = m_ovf;
    s[2] = m_active;
    s[1] = (n == 0);
    s[0] = (n == DEPTH);
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] i);
    case (i)
      2'd0, 2'd1: return m_status();
      2'd2:       return {16'h0000, m_div};
      default:    return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      m_active  = 1'b0;
      m_ovf     = 1'b0;
      m_div     = 16'd4;
      m_edge    = 0;
      m_start   = 0;
      m_period  = 1;
      m_byte    = 8'h00;
      exp_rdata = 32'h0;
      exp_sel   = 1'b0;
      exp_tx    = 1'b1;
    end else begin
      m_edge++;
      m_hit    = hit_of(address);
      m_rd_val = m_read(address[3:2]);
      m_do_pop = !m_active && (mq.size() > 0);
      if (m_active && (m_edge == m_start + 10 * m_period)) m_active = 1'b0;
      if (m_do_pop) begin
        m_byte   = mq.pop_front();
        m_start  = m_edge;
        m_period = (m_div == 16'd0) ? 1 : int'(m_div);
        m_active = 1'b1;
      end
      if (m_hit && we) begin
        case (address[3:2])
          2'd0: if (mq.size() < DEPTH) mq.push_back(wdata[7:0]); else m_ovf = 1'b1;
          2'd1: if (wdata[3]) m_ovf = 1'b0;
          2'd2: m_div = wdata[15:0];
          default: ;
        endcase
      end
      exp_sel = m_hit && !we;
      if (m_hit && !we) exp_rdata = m_rd_val;
      if (m_active) begin
        m_t = m_edge - m_start;
        m_b = m_t / m_period;
        if (m_b == 0)      exp_tx = 1'b0;
        else if (m_b <= 8) exp_tx = m_byte[m_b-1];
        else               exp_tx = 1'b1;
      end else begin
        exp_tx = 1'b1;
      end
    end
  end

  // One bus cycle: drive while the clock is low, return at the next falling edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    address = a;
    wdata   = d;
    we      = w;
    @(posedge clk);
    @(negedge clk);
    address = 32'h0;
    wdata   = 32'h0;
    we      = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    address = 32'h0; wdata = 32'h0; we = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL reset_sel got=%b want=0", sel); end
    total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=0", rdata); end
    resetn = 1'b1;
    @(negedge clk);
    cyc(32'h804, 32'h0, 1'b0);
    total++; if (rdata !== 32'h2) begin bad++; $display("[TB] FAIL reset_status got=%h want=00000002", rdata); end
    total++; if (sel !== 1'b1) begin bad++; $display("[TB] FAIL reset_status_sel got=%b want=1", sel); end
    cyc(32'h0, 32'h0, 1'b0);
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL sel_after_idle got=%b want=0", sel); end
    total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx_idle got=%b want=1", tx); end
  endtask

  task automatic test_single_frame();
    int lows;
    lows = 0;
    cyc(32'h800, 32'h55, 1'b1);
    for (int i = 0; i < 46; i++) begin
      cyc(32'h0, 32'h0, 1'b0);
      if (tx === 1'b0) lows++;
      total++;
      if (tx !== exp_tx) begin bad++; $display("[TB] FAIL frame55_tx cycle=%0d got=%b want=%b", i, tx, exp_tx); end
    end
    // 0x55 has four zero data bits plus the start bit, 4 clocks each.
    total++; if (lows != 20) begin bad++; $display("[TB] FAIL frame55_low_clocks got=%0d want=20", lows); end
  endtask

  task automatic test_back_to_back();
    cyc(32'h808, 32'h2, 1'b1);
    cyc(32'h800, 32'hA3, 1'b1);
    cyc(32'h800, 32'h0F, 1'b1);
    for (int i = 0; i < 48; i++) begin
      if (i == 5) cyc(32'h804, 32'h0, 1'b0);
      else        cyc(32'h0, 32'h0, 1'b0);
      total++;
      if (tx !== exp_tx) begin bad++; $display("[TB] FAIL b2b_tx cycle=%0d got=%b want=%b", i, tx, exp_tx); end
      if (i == 5) begin
        total++;
        if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL b2b_status got=%h want=%h", rdata, exp_rdata); end
        total++;
        if (rdata !== 32'h14) begin bad++; $display("[TB] FAIL b2b_status_busy_cnt1 got=%h want=00000014", rdata); end
      end
    end
  endtask

  task automatic test_overflow();
    cyc(32'h808, 32'd100, 1'b1);
    for (int i = 0; i < 10; i++) cyc(32'h800, 32'($urandom_range(0, 255)), 1'b1);
    cyc(32'h804, 32'h0, 1'b0);
    total++; if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL ovf_status got=%h want=%h", rdata, exp_rdata); end
    total++; if (rdata !== 32'h8D) begin bad++; $display("[TB] FAIL ovf_status_const got=%h want=0000008d", rdata); end
    cyc(32'h804, 32'h8, 1'b1);
    cyc(32'h804, 32'h0, 1'b0);
    total++; if (rdata !== 32'h85) begin bad++; $display("[TB] FAIL ovf_cleared got=%h want=00000085", rdata); end
    cyc(32'h808, 32'h0, 1'b0);
    total++; if (rdata !== 32'd100) begin bad++; $display("[TB] FAIL div_readback got=%h want=00000064", rdata); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 200; i++) begin
      cyc(32'h0, 32'h0, 1'b0);
      total++;
      if (tx !== exp_tx) begin bad++; $display("[TB] FAIL slow_tx cycle=%0d got=%b want=%b", i, tx, exp_tx); end
    end
    // Force a data bit of 0 on the line so the asynchronous return to 1 is visible.
    while (exp_tx !== 1'b0 && m_active) cyc(32'h0, 32'h0, 1'b0);
    #1 resetn = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("[TB] FAIL async_reset_tx got=%b want=1", tx); end
    @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    cyc(32'h804, 32'h0, 1'b0);
    total++; if (rdata !== 32'h2) begin bad++; $display("[TB] FAIL post_reset_status got=%h want=00000002", rdata); end
    for (int i = 0; i < 60; i++) begin
      cyc(32'h0, 32'h0, 1'b0);
      total++;
      if (tx !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_idle cycle=%0d got=%b want=1", i, tx); end
    end
  endtask

  task automatic test_decode();
    cyc(32'h000, 32'h41, 1'b1);
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL decode_w000_sel got=%b want=0", sel); end
    cyc(32'h80C, 32'h42, 1'b1);
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL decode_w80c_sel got=%b want=0", sel); end
    cyc(32'h7FC, 32'h0, 1'b0);
    total++; if (sel !== 1'b0) begin bad++; $display("[TB] FAIL decode_r7fc_sel got=%b want=0", sel); end
    cyc(32'h80C, 32'h0, 1'b0);
    total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL decode_r80c got=%h want=0", rdata); end
    cyc(32'h804, 32'h0, 1'b0);
    total++; if (rdata !== 32'h2) begin bad++; $display("[TB] FAIL decode_no_push got=%h want=00000002", rdata); end
    for (int i = 0; i < 12; i++) begin
      cyc(32'h0, 32'h0, 1'b0);
      total++;
      if (tx !== 1'b1) begin bad++; $display("[TB] FAIL decode_tx_idle cycle=%0d got=%b want=1", i, tx); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic        w;
    int          r;
    logic [31:0] nonhit [4];
    nonhit[0] = 32'h000; nonhit[1] = 32'h7FC; nonhit[2] = 32'h810; nonhit[3] = 32'h801;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      a = 32'h0; d = 32'h0; w = 1'b0;
      if (r < 40)      begin a = 32'h0; end
      else if (r < 62) begin a = 32'h800; d = $urandom; w = 1'b1; end
      else if (r < 74) begin a = 32'h804; end
      else if (r < 79) begin a = 32'h800; end
      else if (r < 83) begin a = 32'h808; d = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF0000); w = 1'b1; end
      else if (r < 87) begin a = 32'h804; d = $urandom; w = 1'b1; end
      else if (r < 91) begin a = 32'h808; end
      else if (r < 94) begin a = 32'h80C; end
      else             begin a = nonhit[$urandom_range(0, 3)]; d = $urandom; w = 1'($urandom_range(0, 1)); end
      cyc(a, d, w);
      total++;
      if (tx !== exp_tx) begin bad++; $display("[TB] FAIL rand_tx cycle=%0d got=%b want=%b", i, tx, exp_tx); end
      total++;
      if (sel !== exp_sel) begin bad++; $display("[TB] FAIL rand_sel cycle=%0d got=%b want=%b", i, sel, exp_sel); end
      total++;
      if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rand_rdata cycle=%0d got=%h want=%h", i, rdata, exp_rdata); end
    end
  endtask

  initial begin
    resetn = 1'b0;
    address = 32'h0; wdata = 32'h0; we = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_decode();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
